// File: rtl/drain_pkg.sv
// Shared constants and FSM state type for the systolic-array result drain engine.
package drain_pkg;

    localparam int PTR_W      = 14;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} drain_state_t;

endpackage

// File: rtl/sa_result_drain_if.sv
// Valid/ready byte stream with a last-beat marker, between the drain engine and the host bridge.
interface sa_result_drain_if #(parameter int DATA_W = 8);

    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/drain_fifo.sv
// Small synchronous FIFO with occupancy output; the head entry is presented directly from flops.
module drain_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);
    import drain_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      occ_q;
    logic             do_pop;

    assign do_pop = pop_i && (occ_q != '0);

    // NOTE: storage has no reset; emptiness is tracked by occ_q, so stale entries are never presented.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({wr_en_i, do_pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign valid_o     = (occ_q != '0);
    assign data_o      = valid_o ? mem_q[rd_ptr_q] : '0;
    assign occupancy_o = occ_q;

endmodule

// File: rtl/sa_result_drain.sv
// Reads count bytes from the sa_data port and streams them out with backpressure and a last marker.
// Optional DRAIN_PERF_EN adds a saturating backpressure stall counter (stall_cnt_o).
module sa_result_drain #(
    parameter int PTR_W      = drain_pkg::PTR_W,
    parameter int DATA_W     = drain_pkg::DATA_W,
    parameter int FIFO_DEPTH = drain_pkg::FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [PTR_W-1:0]   base_ptr_i,
    input  logic [PTR_W:0]     count_i,
    output logic               rd_en_o,
    output logic [PTR_W-1:0]   rd_ptr_o,
    input  logic [DATA_W-1:0]  rd_data_i,
    sa_result_drain_if.master  m_axis,
    output logic               busy_o,
    output logic               done_o
`ifdef DRAIN_PERF_EN
    ,
    output logic [15:0]        stall_cnt_o
`endif
);
    import drain_pkg::*;

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    drain_state_t       state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W:0]     issue_left_q, issue_left_d;
    logic [PTR_W:0]     beat_left_q, beat_left_d;
    logic               inflight_q;
    logic [OCC_W-1:0]   occupancy, pending;
    logic               fifo_valid, accept, credit, issue;
    logic [DATA_W-1:0]  fifo_data;

    drain_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (inflight_q),
        .wr_data_i   (rd_data_i),
        .pop_i       (m_axis.ready),
        .valid_o     (fifo_valid),
        .data_o      (fifo_data),
        .occupancy_o (occupancy)
    );

    // A read may only issue if its byte is guaranteed a free FIFO slot on return.
    assign pending = occupancy + OCC_W'(inflight_q);
    assign credit  = pending < OCC_W'(FIFO_DEPTH);
    assign accept  = fifo_valid && m_axis.ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        issue_left_d = issue_left_q;
        beat_left_d  = accept ? beat_left_q - 1'b1 : beat_left_q;
        issue        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    ptr_d        = base_ptr_i;
                    issue_left_d = count_i;
                    beat_left_d  = count_i;
                    state_d      = (count_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue_left_q != '0 && credit) begin
                    issue        = 1'b1;
                    ptr_d        = ptr_q + 1'b1;
                    issue_left_d = issue_left_q - 1'b1;
                end
                if (issue_left_d == '0) state_d = FLUSH;
            end
            FLUSH: begin
                if (beat_left_d == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            issue_left_q <= '0;
            beat_left_q  <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            issue_left_q <= issue_left_d;
            beat_left_q  <= beat_left_d;
            inflight_q   <= issue;
        end
    end

    assign rd_en_o      = issue;
    assign rd_ptr_o     = ptr_q;
    assign m_axis.valid = fifo_valid;
    assign m_axis.data  = fifo_data;
    assign m_axis.last  = fifo_valid && (beat_left_q == (PTR_W+1)'(1));
    assign busy_o       = (state_q == RUN) || (state_q == FLUSH);
    assign done_o       = (state_q == DONE);

`ifdef DRAIN_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            stall_q <= '0;
        end else if (busy_o && fifo_valid && !m_axis.ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed self-checking bench for sa_result_drain with a 1-cycle-latency read port model.
module tb_sa_result_drain;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [13:0] base_ptr_i;
    logic [14:0] count_i;
    logic        rd_en_o;
    logic [13:0] rd_ptr_o;
    logic [7:0]  rd_data_i;
    logic        busy_o;
    logic        done_o;
`ifdef DRAIN_PERF_EN
    logic [15:0] stall_cnt_o;
`endif

    sa_result_drain_if #(.DATA_W(8)) s_if ();

    sa_result_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .base_ptr_i (base_ptr_i),
        .count_i    (count_i),
        .rd_en_o    (rd_en_o),
        .rd_ptr_o   (rd_ptr_o),
        .rd_data_i  (rd_data_i),
        .m_axis     (s_if.master),
        .busy_o     (busy_o),
        .done_o     (done_o)
`ifdef DRAIN_PERF_EN
        ,
        .stall_cnt_o(stall_cnt_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_byte(input logic [13:0] a);
        return a[7:0] ^ {a[13:8], 2'b01};
    endfunction

    always @(posedge clk) begin
        if (rd_en_o) rd_data_i <= mem_byte(rd_ptr_o);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]  beat_data[$];
    bit          beat_last[$];
    int          beat_cyc[$];
    logic [13:0] rd_log[$];
    int          rd_cyc[$];
    int          done_cyc[$];
    bit          hold_pend = 1'b0;
    logic [8:0]  hold_val;

    // Observe on the falling edge: log reads, beats, done pulses; enforce hold-until-accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("stable_valid", s_if.valid, 1);
                check("stable_beat", {s_if.last, s_if.data}, hold_val);
            end
            if (rd_en_o) begin
                rd_log.push_back(rd_ptr_o);
                rd_cyc.push_back(cyc);
            end
            if (s_if.valid && s_if.ready) begin
                beat_data.push_back(s_if.data);
                beat_last.push_back(s_if.last);
                beat_cyc.push_back(cyc);
            end
            if (done_o) done_cyc.push_back(cyc);
            hold_pend = s_if.valid && !s_if.ready;
            hold_val  = {s_if.last, s_if.data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        beat_data.delete(); beat_last.delete(); beat_cyc.delete();
        rd_log.delete(); rd_cyc.delete(); done_cyc.delete();
    endtask

    task automatic kick(input logic [13:0] base, input logic [14:0] cnt, output int t);
        start_i    = 1'b1;
        base_ptr_i = base;
        count_i    = cnt;
        t          = cyc;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit && done_cyc.size() == 0; i++) tick();
        check({tag, "_done_seen"}, done_cyc.size() != 0, 1);
    endtask

    // Checks count, in-order data from base, and a single last on the final beat.
    task automatic check_beats(input string tag, input logic [13:0] base, input int n);
        int errs;
        int nlast;
        errs  = 0;
        nlast = 0;
        check({tag, "_beats"}, beat_data.size(), n);
        foreach (beat_data[i]) begin
            if (beat_data[i] !== mem_byte(base + 14'(i))) errs++;
            if (beat_last[i]) nlast++;
        end
        check({tag, "_data_errs"}, errs, 0);
        check({tag, "_last_count"}, nlast, 1);
        check({tag, "_last_on_final"}, beat_last.size() > 0 ? beat_last[$] : 1'b0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"}, rd_en_o, 0);
        check({tag, "_rd_ptr"}, rd_ptr_o, 0);
        check({tag, "_m_valid"}, s_if.valid, 0);
        check({tag, "_m_data"}, s_if.data, 0);
        check({tag, "_m_last"}, s_if.last, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
`ifdef DRAIN_PERF_EN
        check({tag, "_stall_cnt"}, stall_cnt_o, 0);
`endif
    endtask

    initial begin
        int t0;
        int bub;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        base_ptr_i = '0;
        count_i    = '0;
        s_if.ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Single-byte read
        clear_logs();
        s_if.ready = 1'b1;
        kick(14'h0010, 15'd1, t0);
        check("t1_busy", busy_o, 1);
        wait_done("t1", 20);
        check("t1_reads", rd_log.size(), 1);
        check("t1_rd_ptr", rd_log.size() > 0 ? rd_log[0] : 14'h3FFF, 14'h0010);
        check("t1_rd_cyc", rd_cyc.size() > 0 ? rd_cyc[0] : -1, t0 + 1);
        check_beats("t1", 14'h0010, 1);
        check("t1_beat_cyc", beat_cyc.size() > 0 ? beat_cyc[0] : -1, t0 + 3);
        check("t1_done_cyc", done_cyc.size() > 0 ? done_cyc[0] : -1, t0 + 4);
        tick();

        // Sustained stream
        clear_logs();
        kick(14'h0000, 15'd256, t0);
        wait_done("t2", 400);
        check_beats("t2", 14'h0000, 256);
        bub = 0;
        foreach (beat_cyc[i]) if (beat_cyc[i] != beat_cyc[0] + i) bub++;
        check("t2_bubbles", bub, 0);
        check("t2_first_beat", beat_cyc.size() > 0 ? beat_cyc[0] : -1, t0 + 3);
        check("t2_done_cyc", done_cyc.size() > 0 ? done_cyc[0] : -1,
              beat_cyc.size() > 0 ? beat_cyc[$] + 1 : -2);
        tick();

        // Full backpressure, then release
        clear_logs();
        s_if.ready = 1'b0;
        kick(14'h0100, 15'd10, t0);
        repeat (19) tick();
        check("t3_reads_held", rd_log.size(), 4);
        check("t3_beats_held", beat_data.size(), 0);
        s_if.ready = 1'b1;
        wait_done("t3", 60);
        check_beats("t3", 14'h0100, 10);
        check("t3_first_accept", beat_cyc.size() > 0 ? beat_cyc[0] : -1, t0 + 20);
        check("t3_resume_cyc", rd_cyc.size() > 4 ? rd_cyc[4] : -1, t0 + 21);
`ifdef DRAIN_PERF_EN
        check("t3_stall_cnt", stall_cnt_o, 17);
`endif
        tick();

        // Address wrap
        clear_logs();
        kick(14'h3FFE, 15'd4, t0);
        wait_done("t4", 30);
        check("t4_reads", rd_log.size(), 4);
        check("t4_ptr0", rd_log.size() > 0 ? rd_log[0] : 14'h1234, 14'h3FFE);
        check("t4_ptr1", rd_log.size() > 1 ? rd_log[1] : 14'h1234, 14'h3FFF);
        check("t4_ptr2", rd_log.size() > 2 ? rd_log[2] : 14'h1234, 14'h0000);
        check("t4_ptr3", rd_log.size() > 3 ? rd_log[3] : 14'h1234, 14'h0001);
        check_beats("t4", 14'h3FFE, 4);
        tick();

        // Zero count
        clear_logs();
        kick(14'h0050, 15'd0, t0);
        wait_done("t5a", 10);
        check("t5a_done_cyc", done_cyc.size() > 0 ? done_cyc[0] : -1, t0 + 1);
        check("t5a_reads", rd_log.size(), 0);
        check("t5a_beats", beat_data.size(), 0);
        tick();

        // Start while busy is ignored
        clear_logs();
        kick(14'h0200, 15'd8, t0);
        tick();
        start_i    = 1'b1;
        base_ptr_i = 14'h0300;
        count_i    = 15'd5;
        tick();
        start_i = 1'b0;
        wait_done("t5b", 40);
        check("t5b_reads", rd_log.size(), 8);
        check("t5b_last_ptr", rd_log.size() > 0 ? rd_log[$] : 14'h0, 14'h0207);
        check_beats("t5b", 14'h0200, 8);
        tick();

        // Reset mid-transfer
        clear_logs();
        s_if.ready = 1'b0;
        kick(14'h0040, 15'd20, t0);
        repeat (6) tick();
        s_if.ready = 1'b1;
        for (int i = 0; i < 40 && beat_data.size() < 5; i++) tick();
        check("t6_five_beats", beat_data.size(), 5);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        kick(14'h0080, 15'd3, t0);
        wait_done("t6b", 30);
        check("t6b_reads", rd_log.size(), 3);
        check_beats("t6b", 14'h0080, 3);
        check("t6b_done_cyc", done_cyc.size() > 0 ? done_cyc[0] : -1, t0 + 6);
`ifdef DRAIN_PERF_EN
        check("t6b_stall_cnt", stall_cnt_o, 0);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
